ebr_ram_rd_arbiter: RTL and testbench
=====================================

# ebr_ram_rd_arbiter

Round-robin arbiter sharing the single read port of one `ebr_ram` instance between two requesters. Each requester gets its own address and data handshake. In-flight reads are tracked in a tag FIFO so each returned data word goes only to the requester that issued the address. The block sits directly between the requesters and `ebr_ram`'s read-address and read-data interfaces; the RAM write port is not routed through it.

## Interface
- `WIDTH`, 16, data width; must match the attached `ebr_ram`.
- `DEPTH`, 1024, RAM depth; address width is `$clog2(DEPTH)`.
- `MAX_OUTSTANDING`, 4, tag FIFO depth and maximum number of in-flight reads; power of two, ≥ 2.

- `i_clock`  in  1  single clock for all logic.
- `i_reset_n`  in  1  reset, synchronous, active-low.
- `i_req0_addr` / `i_req1_addr`  in  `$clog2(DEPTH)`  requester read address.
- `i_req0_addr_valid` / `i_req1_addr_valid`  in  1  address valid.
- `o_req0_addr_ready` / `o_req1_addr_ready`  out  1  address accepted this cycle.
- `o_req0_data` / `o_req1_data`  out  WIDTH  returned read data.
- `o_req0_valid` / `o_req1_valid`  out  1  returned data valid.
- `i_req0_ready` / `i_req1_ready`  in  1  requester accepts data.
- `o_ram_addr`  out  `$clog2(DEPTH)`  to RAM `i_out_addr`.
- `o_ram_addr_valid`  out  1  to RAM `i_out_addr_valid`.
- `i_ram_addr_ready`  in  1  from RAM `o_out_addr_ready`.
- `i_ram_data`  in  WIDTH  from RAM `o_out_data`.
- `i_ram_valid`  in  1  from RAM `o_out_valid`.
- `o_ram_ready`  out  1  to RAM `i_out_ready`.
- `o_outstanding`  out  `$clog2(MAX_OUTSTANDING+1)`  number of in-flight reads.
- `o_orphan`  out  1  sticky error: RAM returned data while no tag was pending.

## Operation
**Registered state**
- Round-robin pointer `last`: the ID of the last granted requester.
- Tag FIFO holding 1-bit requester IDs, `MAX_OUTSTANDING` entries.
- Counter `o_outstanding`.
- Sticky flag `o_orphan`.

**Grant (combinational)**
- If only one requester is valid, grant it.
- If both are valid, grant `!last`.
- If neither is valid, the grant is don't-care.

**Address path**
- `full = (o_outstanding == MAX_OUTSTANDING)`.
- `o_ram_addr_valid = (i_req0_addr_valid | i_req1_addr_valid) & !full`. It never depends on `i_ram_addr_ready`.
- `o_ram_addr` = address of the granted requester.
- `o_reqN_addr_ready = i_reqN_addr_valid & grant==N & i_ram_addr_ready & !full`.
- On accept (`o_ram_addr_valid & i_ram_addr_ready`): push the grant ID into the tag FIFO and set `last` to the grant.
- `last` is unchanged on any cycle without an accept.

**Return path**
- The RAM returns data strictly in address order; the FIFO head is the owner of the next return.
- `o_reqN_valid = i_ram_valid & !empty & head==N`.
- Both `o_reqN_data` outputs are driven with `i_ram_data`.
- `o_ram_ready = empty ? 1 : i_req[head]_ready`.
- On a return handshake with a non-empty FIFO: pop the tag.
- Head-of-line blocking is intended: a stalled head owner also stalls the other requester's returns.

**Counter**
- `+1` on accept, `-1` on return pop.
- Both in the same cycle: unchanged.
- It never exceeds `MAX_OUTSTANDING` and never goes below 0.

**Boundary conditions**
- Full: no accept, even if a pop occurs in the same cycle. The freed slot is usable from the next cycle.
- Empty FIFO with `i_ram_valid=1`: no requester sees valid, the word is drained (`o_ram_ready=1`), and `o_orphan` is set. `o_orphan` stays set until reset.
- Tag FIFO pointers wrap modulo `MAX_OUTSTANDING`.

**Reset** (`i_reset_n=0` at a rising edge)
- Tag FIFO emptied, `o_outstanding=0`, `last=1` (requester 0 wins the first tie), `o_orphan=0`.
- The attached RAM is reset by the same reset, so no stale returns are expected. Any stale return that does arrive is flagged as orphan.

## Timing
- Zero added latency on both paths: the address reaches the RAM in the same cycle it is presented, and data reaches the requester in the same cycle the RAM presents it.
- Combinational paths:
  - `i_ram_addr_ready` → `o_reqN_addr_ready`.
  - `i_reqN_ready` → `o_ram_ready`.
  - `i_ram_valid` / `i_ram_data` → requester outputs.
- Output values while in reset and in the first cycle after reset, with all inputs low:
  - All `o_reqN_addr_ready`, `o_reqN_valid` and `o_ram_addr_valid` are 0.
  - `o_ram_ready` is 1, because the FIFO is empty.
  - `o_outstanding` and `o_orphan` are 0.
- A requester must hold address and valid stable until ready. The block holds its grant stable while the RAM stalls, because `last` only updates on accept.
- Sustained throughput is one read per cycle when the RAM and the head owner are always ready.

## Test plan
1. **Reset values.** Assert `i_reset_n=0` for 10 cycles with random inputs, then release with inputs low → the output values listed under Timing.
2. **Single requester.** RAM preloaded via its write port with `data = 999-addr` for addr 0..999. Requester 0 reads 0..999 back-to-back → 1000 words on `o_req0_*` in order, values 999..0. Requester 1 sees no valid.
3. **Contention.** Both requesters held continuously valid: req0 reads addresses 0..499, req1 reads 500..999 → grants alternate 0,1,0,1 starting with 0. Each requester receives exactly 500 words, each equal to `999-addr` of its own requests.
4. **Backpressure.** Hold `i_req1_ready=0` for 20 cycles during contention:
   - `o_outstanding` saturates at 4 and both address readies drop.
   - Req0 returns stall once a req1 tag reaches the head.
   - After release, all 1000 words are delivered with no loss or duplication.
5. **Orphan.** With a stub RAM model, pulse `i_ram_valid` while the FIFO is empty → neither `o_reqN_valid` asserts, `o_ram_ready=1`, and `o_orphan=1` persists until the next reset.
6. **Mid-operation reset.** Reset with 3 reads outstanding → next cycle `o_outstanding=0` and no `o_reqN_valid`. A subsequent single read returns the correct data to the correct requester.

Source files
------------

// File: rtl/ebr_ram_rd_arbiter.sv
// ebr_ram_rd_arbiter
// Round-robin arbiter sharing the single read port of one ebr_ram between two
// requesters. Each accepted address pushes the owner ID into a small tag FIFO.
// Returned words are steered to the owner at the FIFO head. The RAM returns data
// in address order, so the head is always the owner of the next word.
//
// Ports:
//   i_clock, i_reset_n            clock, synchronous active-low reset
//   i_reqN_addr/_addr_valid       requester N read address handshake (in)
//   o_reqN_addr_ready             requester N address accepted this cycle
//   o_reqN_data/_valid            returned data to requester N
//   i_reqN_ready                  requester N accepts returned data
//   o_ram_addr/_addr_valid        address to the RAM read port
//   i_ram_addr_ready              RAM accepts the address
//   i_ram_data/_valid             read data from the RAM
//   o_ram_ready                   arbiter accepts the RAM word
//   o_outstanding                 number of in-flight reads
//   o_orphan                      sticky: RAM returned data with no pending tag
module ebr_ram_rd_arbiter #(
  parameter int WIDTH           = 16,
  parameter int DEPTH           = 1024,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                   i_clock,
  input  logic                                   i_reset_n,
  input  logic [$clog2(DEPTH)-1:0]               i_req0_addr,
  input  logic                                   i_req0_addr_valid,
  output logic                                   o_req0_addr_ready,
  input  logic [$clog2(DEPTH)-1:0]               i_req1_addr,
  input  logic                                   i_req1_addr_valid,
  output logic                                   o_req1_addr_ready,
  output logic [WIDTH-1:0]                       o_req0_data,
  output logic                                   o_req0_valid,
  input  logic                                   i_req0_ready,
  output logic [WIDTH-1:0]                       o_req1_data,
  output logic                                   o_req1_valid,
  input  logic                                   i_req1_ready,
  output logic [$clog2(DEPTH)-1:0]               o_ram_addr,
  output logic                                   o_ram_addr_valid,
  input  logic                                   i_ram_addr_ready,
  input  logic [WIDTH-1:0]                       i_ram_data,
  input  logic                                   i_ram_valid,
  output logic                                   o_ram_ready,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   o_outstanding,
  output logic                                   o_orphan
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam logic [CW-1:0] FULL_CNT = CW'(MAX_OUTSTANDING);

  logic          last;
  logic          tag_mem [MAX_OUTSTANDING];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] outstanding;
  logic          orphan;

  logic grant;
  logic full;
  logic empty;
  logic head;
  logic accept;
  logic pop;

  // Address path: grant selection and RAM address handshake
  always_comb begin
    full  = (outstanding == FULL_CNT);
    empty = (outstanding == '0);
    // On a tie the requester not granted last wins; otherwise the lone valid one.
    grant = (i_req0_addr_valid & i_req1_addr_valid) ? ~last : i_req1_addr_valid;

    o_ram_addr_valid  = (i_req0_addr_valid | i_req1_addr_valid) & ~full;
    o_ram_addr        = grant ? i_req1_addr : i_req0_addr;
    o_req0_addr_ready = i_req0_addr_valid & ~grant & i_ram_addr_ready & ~full;
    o_req1_addr_ready = i_req1_addr_valid &  grant & i_ram_addr_ready & ~full;
    accept            = o_ram_addr_valid & i_ram_addr_ready;
  end

  // Return path: steer the RAM word to the owner at the tag FIFO head
  always_comb begin
    head         = tag_mem[rd_ptr];
    o_req0_data  = i_ram_data;
    o_req1_data  = i_ram_data;
    o_req0_valid = i_ram_valid & ~empty & ~head;
    o_req1_valid = i_ram_valid & ~empty &  head;
    // With nothing pending any word is an orphan and is drained.
    o_ram_ready  = empty ? 1'b1 : (head ? i_req1_ready : i_req0_ready);
    pop          = i_ram_valid & o_ram_ready & ~empty;
  end

  // Control state
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      last        <= 1'b1;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
      orphan      <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + PW'(1);
        last   <= grant;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (accept && !pop) begin
        outstanding <= outstanding + CW'(1);
      end else if (pop && !accept) begin
        outstanding <= outstanding - CW'(1);
      end
      if (i_ram_valid && empty) begin
        orphan <= 1'b1;
      end
    end
  end

  // Tag storage; only entries between the pointers are meaningful
  always_ff @(posedge i_clock) begin
    if (accept) begin
      tag_mem[wr_ptr] <= grant;
    end
  end

  assign o_outstanding = outstanding;
  assign o_orphan      = orphan;

endmodule

// File: tb/tb_ebr_ram_rd_arbiter.sv
module tb_ebr_ram_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  req0_addr, req1_addr;
  logic        req0_av, req1_av;
  logic        req0_ar, req1_ar;
  logic [15:0] req0_data, req1_data;
  logic        req0_v, req1_v;
  logic        req0_rdy, req1_rdy;
  logic [9:0]  ram_addr;
  logic        ram_addr_valid;
  logic        ram_addr_ready;
  logic [15:0] ram_data;
  logic        ram_valid;
  logic        ram_ready;
  logic [2:0]  outstanding;
  logic        orphan;

  // RAM model / stub
  logic        stub_mode;
  logic        stub_valid;
  logic [15:0] stub_data;
  logic        mdl_valid;
  logic [15:0] mdl_data;
  logic [15:0] ram_q[$];

  // Scoreboard
  logic [15:0] exp0[$];
  logic [15:0] exp1[$];
  bit          glog[$];
  int          tests = 0;
  int          fails = 0;
  int          rx0 = 0;
  int          rx1 = 0;

  always #5 clk = ~clk;

  ebr_ram_rd_arbiter #(.WIDTH(16), .DEPTH(1024), .MAX_OUTSTANDING(4)) dut (
    .i_clock           (clk),
    .i_reset_n         (rst_n),
    .i_req0_addr       (req0_addr),
    .i_req0_addr_valid (req0_av),
    .o_req0_addr_ready (req0_ar),
    .i_req1_addr       (req1_addr),
    .i_req1_addr_valid (req1_av),
    .o_req1_addr_ready (req1_ar),
    .o_req0_data       (req0_data),
    .o_req0_valid      (req0_v),
    .i_req0_ready      (req0_rdy),
    .o_req1_data       (req1_data),
    .o_req1_valid      (req1_v),
    .i_req1_ready      (req1_rdy),
    .o_ram_addr        (ram_addr),
    .o_ram_addr_valid  (ram_addr_valid),
    .i_ram_addr_ready  (ram_addr_ready),
    .i_ram_data        (ram_data),
    .i_ram_valid       (ram_valid),
    .o_ram_ready       (ram_ready),
    .o_outstanding     (outstanding),
    .o_orphan          (orphan)
  );

  assign ram_valid = stub_mode ? stub_valid : mdl_valid;
  assign ram_data  = stub_mode ? stub_data  : mdl_data;

  // In-order RAM with one cycle read latency, contents data = 999 - addr
  always @(posedge clk) begin
    if (!rst_n) begin
      ram_q.delete();
      mdl_valid <= 1'b0;
      mdl_data  <= 16'h0;
    end else begin
      if (!stub_mode && mdl_valid && ram_ready) void'(ram_q.pop_front());
      if (ram_addr_valid && ram_addr_ready) ram_q.push_back(16'(999 - int'(ram_addr)));
      mdl_valid <= (ram_q.size() != 0);
      mdl_data  <= (ram_q.size() != 0) ? ram_q[0] : 16'h0;
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pushes expectations on address accept, pops on data handshake
  always @(negedge clk) begin
    logic [15:0] e;
    if (!rst_n) begin
      exp0.delete();
      exp1.delete();
    end else begin
      if (req0_v && req1_v) check("both_valid", 1, 0);
      if (req0_v && req0_rdy) begin
        if (exp0.size() == 0) check("req0_unexpected_valid", 1, 0);
        else begin
          e = exp0.pop_front();
          check("req0_data", req0_data, e);
          rx0++;
        end
      end
      if (req1_v && req1_rdy) begin
        if (exp1.size() == 0) check("req1_unexpected_valid", 1, 0);
        else begin
          e = exp1.pop_front();
          check("req1_data", req1_data, e);
          rx1++;
        end
      end
      if (req0_ar) begin
        check("ram_addr_req0", ram_addr, req0_addr);
        exp0.push_back(16'(999 - int'(req0_addr)));
        glog.push_back(1'b0);
      end
      if (req1_ar) begin
        check("ram_addr_req1", ram_addr, req1_addr);
        exp1.push_back(16'(999 - int'(req1_addr)));
        glog.push_back(1'b1);
      end
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic drive0(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      req0_addr = 10'(base + i);
      req0_av   = 1'b1;
      do @(negedge clk); while (!req0_ar);
      step();
    end
    req0_av = 1'b0;
  endtask

  task automatic drive1(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      req1_addr = 10'(base + i);
      req1_av   = 1'b1;
      do @(negedge clk); while (!req1_ar);
      step();
    end
    req1_av = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp0.size() != 0 || exp1.size() != 0 || outstanding != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check(name, (n < 500) ? 1 : 0, 1);
    step();
  endtask

  initial begin
    int bad;
    int rx1_snap;
    rst_n = 1'b0; req0_addr = '0; req1_addr = '0; req0_av = 0; req1_av = 0;
    req0_rdy = 0; req1_rdy = 0; ram_addr_ready = 0;
    stub_mode = 1'b1; stub_valid = 1'b0; stub_data = '0;

    // Reset with random inputs, then release with inputs low
    for (int i = 0; i < 10; i++) begin
      step();
      req0_addr = 10'($urandom); req1_addr = 10'($urandom);
      req0_av = 1'($urandom); req1_av = 1'($urandom);
      req0_rdy = 1'($urandom); req1_rdy = 1'($urandom);
      ram_addr_ready = 1'($urandom);
      stub_valid = 1'($urandom); stub_data = 16'($urandom);
    end
    step();
    req0_av = 0; req1_av = 0; req0_rdy = 0; req1_rdy = 0; ram_addr_ready = 0;
    stub_valid = 0; stub_data = '0; req0_addr = '0; req1_addr = '0;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_req0_addr_ready", req0_ar, 0);
    check("rst_req1_addr_ready", req1_ar, 0);
    check("rst_req0_valid", req0_v, 0);
    check("rst_req1_valid", req1_v, 0);
    check("rst_ram_addr_valid", ram_addr_valid, 0);
    check("rst_ram_ready", ram_ready, 1);
    check("rst_outstanding", outstanding, 0);
    check("rst_orphan", orphan, 0);
    step();
    stub_mode = 1'b0; ram_addr_ready = 1'b1; req0_rdy = 1'b1; req1_rdy = 1'b1;

    // Single requester: req0 reads 0..999 back to back
    rx0 = 0; rx1 = 0;
    drive0(0, 1000);
    wait_drain("single_drain");
    check("single_rx0", rx0, 1000);
    check("single_rx1", rx1, 0);
    check("single_orphan", orphan, 0);

    // Contention: alternating grants starting with requester 0
    do_reset();
    rx0 = 0; rx1 = 0; glog.delete();
    fork
      drive0(0, 500);
      drive1(500, 500);
    join
    wait_drain("contend_drain");
    check("contend_rx0", rx0, 500);
    check("contend_rx1", rx1, 500);
    check("contend_grants", glog.size(), 1000);
    bad = -1;
    for (int i = 0; i < glog.size(); i++) begin
      if (glog[i] != bit'(i % 2) && bad < 0) bad = i;
    end
    check("contend_grant_first_bad", bad, -1);

    // Backpressure: req1 stalls the shared return path
    do_reset();
    rx0 = 0; rx1 = 0;
    fork
      drive0(0, 500);
      drive1(500, 500);
      begin
        repeat (10) step();
        req1_rdy = 1'b0;
        repeat (20) step();
        @(negedge clk);
        check("bp_outstanding", outstanding, 4);
        check("bp_req0_addr_ready", req0_ar, 0);
        check("bp_req1_addr_ready", req1_ar, 0);
        check("bp_ram_addr_valid", ram_addr_valid, 0);
        check("bp_req0_valid", req0_v, 0);
        check("bp_req1_valid", req1_v, 1);
        check("bp_ram_ready", ram_ready, 0);
        step();
        req1_rdy = 1'b1;
      end
    join
    wait_drain("bp_drain");
    check("bp_rx0", rx0, 500);
    check("bp_rx1", rx1, 500);
    check("bp_orphan", orphan, 0);

    // Orphan: stub return with an empty FIFO
    stub_mode = 1'b1; stub_valid = 1'b1; stub_data = 16'hBEEF;
    @(negedge clk);
    check("orph_req0_valid", req0_v, 0);
    check("orph_req1_valid", req1_v, 0);
    check("orph_ram_ready", ram_ready, 1);
    check("orph_before_edge", orphan, 0);
    step();
    stub_valid = 1'b0;
    @(negedge clk);
    check("orph_set", orphan, 1);
    repeat (5) step();
    @(negedge clk);
    check("orph_sticky", orphan, 1);
    step();
    stub_mode = 1'b0;
    do_reset();
    @(negedge clk);
    check("orph_cleared", orphan, 0);
    step();

    // Mid-operation reset with three reads outstanding
    req0_rdy = 1'b0;
    drive0(10, 3);
    @(negedge clk);
    check("mid_outstanding_3", outstanding, 3);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_outstanding_0", outstanding, 0);
    check("mid_req0_valid", req0_v, 0);
    check("mid_req1_valid", req1_v, 0);
    step();
    req0_rdy = 1'b1;
    rx1_snap = rx1;
    drive1(42, 1);
    wait_drain("mid_drain");
    check("mid_rx1", rx1 - rx1_snap, 1);
    check("mid_orphan", orphan, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
